// File: rtl/alu_driver.sv
// alu_driver: request/response sequencer that drives a combinational ALU from
// registers, waits ALU_LAT settle cycles, then captures and returns the result.
// Optional feature macro: ALU_DRV_STICKY_EN (sticky overflow flag plus a
// saturating overflow counter); when undefined those outputs are tied to 0.

package alu_driver_pkg;
  localparam int unsigned WordW    = 32;
  localparam int unsigned RegBitsW = 5;

  typedef logic [WordW-1:0]    word_t;
  typedef logic [RegBitsW-1:0] regbits_t;

  // Captured ALU response payload
  typedef struct packed {
    word_t result;
    logic  neg;
    logic  ovf;
    logic  zero;
  } aluRsp_t;

  // Operand/opcode payload presented to the ALU
  typedef struct packed {
    word_t    a;
    word_t    b;
    regbits_t op;
  } aluReq_t;
endpackage

module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  word_t      req_a,
  input  word_t      req_b,
  input  regbits_t   req_op,
  output word_t      PortA,
  output word_t      PortB,
  output regbits_t   ALUOP,
  input  word_t      OutputPort,
  input  logic       NegFlag,
  input  logic       Overflow,
  input  logic       ZeroFlag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output word_t      rsp_result,
  output logic       rsp_neg,
  output logic       rsp_ovf,
  output logic       rsp_zero,
  input  logic       clr_sticky,
  output logic       ovf_sticky,
  output logic [7:0] ovf_count
);

  localparam int unsigned CntW    = 4;
  localparam int unsigned OvfCntW = 8;

  // Settle count must fit the counter and be at least one cycle
  if (ALU_LAT < 1 || ALU_LAT > 15) begin : gBadLat
    $error("alu_driver: ALU_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cntNext;
  logic            loadReq;
  logic            capture;
  logic            rspValidNext;
  aluReq_t         reqQ;
  aluRsp_t         rspQ;

  // State and settle-counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state, handshake and load/capture strobes
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    req_ready    = 1'b0;
    loadReq      = 1'b0;
    capture      = 1'b0;
    rspValidNext = rsp_valid;
    unique case (state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          loadReq   = 1'b1;
          cntNext   = CntW'(ALU_LAT);
          stateNext = StWait;
        end
      end
      StWait: begin
        cntNext = cnt - CntW'(1);
        if (cnt == CntW'(1)) begin
          capture      = 1'b1;
          rspValidNext = 1'b1;
          stateNext    = StResp;
        end
      end
      StResp: begin
        // Response consumption frees the slot in the same cycle
        req_ready    = rsp_ready;
        rspValidNext = 1'b1;
        if (rsp_ready) begin
          rspValidNext = 1'b0;
          if (req_valid) begin
            loadReq   = 1'b1;
            cntNext   = CntW'(ALU_LAT);
            stateNext = StWait;
          end else begin
            stateNext = StIdle;
          end
        end
      end
      default: begin
        stateNext    = StIdle;
        rspValidNext = 1'b0;
      end
    endcase
  end

  // ALU operand registers: change only on request acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      reqQ <= '0;
    end else if (loadReq) begin
      reqQ <= '{a: req_a, b: req_b, op: req_op};
    end
  end

  // Response registers: payload holds after consumption, valid qualifies it
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rspQ      <= '0;
    end else begin
      rsp_valid <= rspValidNext;
      if (capture) begin
        rspQ <= '{result: OutputPort, neg: NegFlag, ovf: Overflow, zero: ZeroFlag};
      end
    end
  end

  assign PortA      = reqQ.a;
  assign PortB      = reqQ.b;
  assign ALUOP      = reqQ.op;
  assign rsp_result = rspQ.result;
  assign rsp_neg    = rspQ.neg;
  assign rsp_ovf    = rspQ.ovf;
  assign rsp_zero   = rspQ.zero;

`ifdef ALU_DRV_STICKY_EN
  logic               stickyQ;
  logic [OvfCntW-1:0] ovfCntQ;

  // Sticky overflow and saturating count; clear beats a coincident capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      stickyQ <= 1'b0;
      ovfCntQ <= '0;
    end else if (clr_sticky) begin
      stickyQ <= 1'b0;
      ovfCntQ <= '0;
    end else if (capture && Overflow) begin
      stickyQ <= 1'b1;
      if (ovfCntQ != '1) begin
        ovfCntQ <= ovfCntQ + OvfCntW'(1);
      end
    end
  end

  assign ovf_sticky = stickyQ;
  assign ovf_count  = ovfCntQ;
`else
  logic unusedClrSticky;
  assign unusedClrSticky = clr_sticky;
  assign ovf_sticky      = 1'b0;
  assign ovf_count       = '0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed bench with an ALU model and response scoreboards.
// Instance A uses ALU_LAT=1, instance B uses ALU_LAT=3.
module tb_alu_driver;

  localparam logic [4:0] OpAdd = 5'd0;
  localparam logic [4:0] OpSub = 5'd1;
  localparam logic [4:0] OpAnd = 5'd2;

  typedef struct packed {
    logic [31:0] result;
    logic        neg;
    logic        ovf;
    logic        zero;
  } exp_t;

  // Reference combinational ALU
  function automatic exp_t aluModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] op);
    exp_t        r;
    logic [31:0] res;
    logic        ovf;
    res = '0;
    ovf = 1'b0;
    case (op)
      OpAdd: begin
        res = a + b;
        ovf = (a[31] == b[31]) && (res[31] != a[31]);
      end
      OpSub: begin
        res = a - b;
        ovf = (a[31] != b[31]) && (res[31] != a[31]);
      end
      default: res = a & b;
    endcase
    r.result = res;
    r.neg    = res[31];
    r.ovf    = ovf;
    r.zero   = (res == 32'd0);
    return r;
  endfunction

  logic CLK = 1'b0;
  logic RST;
  logic clrSticky;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  always @(posedge CLK) cycle++;

  // Instance A signals
  logic        aReqValid, aReqReady, aRspValid, aRspReady;
  logic [31:0] aReqA, aReqB, aPortA, aPortB, aOut, aRspResult;
  logic [4:0]  aReqOp, aAluOp;
  logic        aNeg, aOvf, aZero, aRspNeg, aRspOvf, aRspZero, aOvfSticky;
  logic [7:0]  aOvfCount;
  // Instance B signals
  logic        bReqValid, bReqReady, bRspValid, bRspReady;
  logic [31:0] bReqA, bReqB, bPortA, bPortB, bOut, bRspResult;
  logic [4:0]  bReqOp, bAluOp;
  logic        bNeg, bOvf, bZero, bRspNeg, bRspOvf, bRspZero, bOvfSticky;
  logic [7:0]  bOvfCount;

  assign {aOut, aNeg, aOvf, aZero} = aluModel(aPortA, aPortB, aAluOp);
  assign {bOut, bNeg, bOvf, bZero} = aluModel(bPortA, bPortB, bAluOp);

  alu_driver #(.ALU_LAT(1)) dutA (
    .CLK(CLK), .RST(RST), .req_valid(aReqValid), .req_ready(aReqReady),
    .req_a(aReqA), .req_b(aReqB), .req_op(aReqOp),
    .PortA(aPortA), .PortB(aPortB), .ALUOP(aAluOp),
    .OutputPort(aOut), .NegFlag(aNeg), .Overflow(aOvf), .ZeroFlag(aZero),
    .rsp_valid(aRspValid), .rsp_ready(aRspReady), .rsp_result(aRspResult),
    .rsp_neg(aRspNeg), .rsp_ovf(aRspOvf), .rsp_zero(aRspZero),
    .clr_sticky(clrSticky), .ovf_sticky(aOvfSticky), .ovf_count(aOvfCount)
  );

  alu_driver #(.ALU_LAT(3)) dutB (
    .CLK(CLK), .RST(RST), .req_valid(bReqValid), .req_ready(bReqReady),
    .req_a(bReqA), .req_b(bReqB), .req_op(bReqOp),
    .PortA(bPortA), .PortB(bPortB), .ALUOP(bAluOp),
    .OutputPort(bOut), .NegFlag(bNeg), .Overflow(bOvf), .ZeroFlag(bZero),
    .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_result(bRspResult),
    .rsp_neg(bRspNeg), .rsp_ovf(bRspOvf), .rsp_zero(bRspZero),
    .clr_sticky(clrSticky), .ovf_sticky(bOvfSticky), .ovf_count(bOvfCount)
  );

  exp_t qA[$];
  exp_t qB[$];
  int   rspCycB[$];
  exp_t aExp, bExp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every response handshake
  always @(negedge CLK) begin
    if (!RST && aRspValid && aRspReady) begin
      if (qA.size() == 0) check("a_unexpected_rsp", 64'(1), 64'(0));
      else begin
        aExp = qA.pop_front();
        check("a_rsp", 64'({aRspResult, aRspNeg, aRspOvf, aRspZero}), 64'(aExp));
      end
    end
    if (!RST && bRspValid && bRspReady) begin
      rspCycB.push_back(cycle);
      if (qB.size() == 0) check("b_unexpected_rsp", 64'(1), 64'(0));
      else begin
        bExp = qB.pop_front();
        check("b_rsp", 64'({bRspResult, bRspNeg, bRspOvf, bRspZero}), 64'(bExp));
      end
    end
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Present a request (call just after a rising edge); returns just after the accepting edge
  task automatic send(input bit useB, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input bit wantRsp);
    int n;
    if (useB) begin
      bReqValid = 1'b1; bReqA = a; bReqB = b; bReqOp = op;
    end else begin
      aReqValid = 1'b1; aReqA = a; aReqB = b; aReqOp = op;
    end
    n = 0;
    @(negedge CLK);
    while (!(useB ? bReqReady : aReqReady) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("req_accept", 64'(useB ? bReqReady : aReqReady), 64'(1));
    if (wantRsp) begin
      if (useB) qB.push_back(aluModel(a, b, op));
      else qA.push_back(aluModel(a, b, op));
    end
    @(posedge CLK);
    #1;
    if (useB) bReqValid = 1'b0;
    else aReqValid = 1'b0;
  endtask

  // Wait (bounded) until the response is valid; returns on a falling edge
  task automatic waitRsp(input bit useB);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(useB ? bRspValid : aRspValid) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("rsp_valid_wait", 64'(useB ? bRspValid : aRspValid), 64'(1));
  endtask

  initial begin
    bit sawValid;
    RST = 1'b1; clrSticky = 1'b0;
    aReqValid = 1'b0; aReqA = '0; aReqB = '0; aReqOp = '0; aRspReady = 1'b1;
    bReqValid = 1'b0; bReqA = '0; bReqB = '0; bReqOp = '0; bRspReady = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 64'(aReqReady), 64'(1));
    check("rst_porta", 64'(aPortA), 64'(0));
    check("rst_portb", 64'(aPortB), 64'(0));
    check("rst_aluop", 64'(aAluOp), 64'(0));
    check("rst_rsp_valid", 64'(aRspValid), 64'(0));
    check("rst_rsp_payload", 64'({aRspResult, aRspNeg, aRspOvf, aRspZero}), 64'(0));
    check("rst_sticky", 64'({aOvfSticky, aOvfCount}), 64'(0));
    nextCycle();
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_req_ready", 64'(aReqReady), 64'(1));
    nextCycle();

    // ADD 3+4 with ALU_LAT=1
    send(1'b0, 32'd3, 32'd4, OpAdd, 1'b1);
    @(negedge CLK);
    check("add_porta", 64'(aPortA), 64'(3));
    check("add_portb", 64'(aPortB), 64'(4));
    check("add_aluop", 64'(aAluOp), 64'(OpAdd));
    check("add_wait_valid", 64'(aRspValid), 64'(0));
    check("add_wait_ready", 64'(aReqReady), 64'(0));
    @(negedge CLK);
    check("add_rsp_valid", 64'(aRspValid), 64'(1));
    check("add_rsp_result", 64'(aRspResult), 64'(7));
    check("add_rsp_flags", 64'({aRspNeg, aRspOvf, aRspZero}), 64'(0));
    nextCycle();

    // Signed overflow
    send(1'b0, 32'h7FFF_FFFF, 32'd1, OpAdd, 1'b1);
    waitRsp(1'b0);
    check("ovf_result", 64'(aRspResult), 64'(32'h8000_0000));
    check("ovf_flags", 64'({aRspNeg, aRspOvf, aRspZero}), 64'(3'b110));
`ifdef ALU_DRV_STICKY_EN
    check("ovf_sticky", 64'(aOvfSticky), 64'(1));
    check("ovf_count", 64'(aOvfCount), 64'(1));
`else
    check("ovf_sticky_tied", 64'(aOvfSticky), 64'(0));
    check("ovf_count_tied", 64'(aOvfCount), 64'(0));
`endif
    nextCycle();

    // SUB 5-5 with response back-pressure
    aRspReady = 1'b0;
    send(1'b0, 32'd5, 32'd5, OpSub, 1'b1);
    waitRsp(1'b0);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 64'(aRspValid), 64'(1));
      check("hold_zero", 64'(aRspZero), 64'(1));
      check("hold_result", 64'(aRspResult), 64'(0));
      check("hold_req_ready", 64'(aReqReady), 64'(0));
      @(negedge CLK);
    end
    nextCycle();
    aRspReady = 1'b1;
    @(negedge CLK);
    check("release_req_ready", 64'(aReqReady), 64'(1));
    nextCycle();
    @(negedge CLK);
    check("idle_valid", 64'(aRspValid), 64'(0));
    check("idle_req_ready", 64'(aReqReady), 64'(1));
    check("idle_payload_held", 64'({aRspResult, aRspZero}), 64'(1));
    nextCycle();

    // Back-to-back on ALU_LAT=3
    send(1'b1, 32'd10, 32'd20, OpAdd, 1'b1);
    send(1'b1, 32'd7, 32'd9, OpSub, 1'b1);
    send(1'b1, 32'h0000_F0F0, 32'h0000_FF00, OpAnd, 1'b1);
    send(1'b1, 32'h8000_0000, 32'd1, OpSub, 1'b1);
    for (int n = 0; n < 40 && qB.size() != 0; n++) @(negedge CLK);
    check("b2b_drained", 64'(qB.size()), 64'(0));
    check("b2b_rsp_count", 64'(rspCycB.size()), 64'(4));
    for (int i = 1; i < rspCycB.size(); i++)
      check("b2b_spacing", 64'(rspCycB[i] - rspCycB[i-1]), 64'(4));
    nextCycle();

    // Reset during WAIT discards the op
    send(1'b1, 32'd1, 32'd2, OpAdd, 1'b0);
    nextCycle();
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_ports", 64'({bPortA, bPortB}), 64'(0));
    check("midrst_aluop", 64'(bAluOp), 64'(0));
    check("midrst_payload", 64'({bRspResult, bRspNeg, bRspOvf, bRspZero}), 64'(0));
    check("midrst_a_payload", 64'({aRspResult, aRspZero}), 64'(0));
    check("midrst_req_ready", 64'(bReqReady), 64'(1));
    check("midrst_sticky", 64'({bOvfSticky, bOvfCount}), 64'(0));
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sawValid |= bRspValid;
      @(negedge CLK);
    end
    check("midrst_no_rsp", 64'(sawValid), 64'(0));
    nextCycle();

`ifdef ALU_DRV_STICKY_EN
    // Saturation, then clear coinciding with an overflow capture
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 32'h7FFF_FFFF, 32'd1, OpAdd, 1'b1);
      waitRsp(1'b0);
      nextCycle();
    end
    @(negedge CLK);
    check("sat_count", 64'(aOvfCount), 64'(255));
    check("sat_sticky", 64'(aOvfSticky), 64'(1));
    nextCycle();
    send(1'b0, 32'h7FFF_FFFF, 32'd1, OpAdd, 1'b1);
    clrSticky = 1'b1;
    nextCycle();
    clrSticky = 1'b0;
    @(negedge CLK);
    check("clr_rsp_ovf", 64'(aRspOvf), 64'(1));
    check("clr_count", 64'(aOvfCount), 64'(0));
    check("clr_sticky", 64'(aOvfSticky), 64'(0));
    nextCycle();
`endif

    repeat (3) nextCycle();
    check("a_queue_empty", 64'(qA.size()), 64'(0));
    check("b_queue_empty", 64'(qB.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Initiator-side sequencer for the ALU interface: accepts operation requests over a valid/ready handshake and drives `PortA`, `PortB` and `ALUOP` into the ALU from registers. After a configurable settle time it captures `OutputPort` and the three flags, then returns them on a valid/ready response channel. It sits between a multi-cycle control unit or test harness and the combinational ALU, so the ALU can be exercised and timed independently of the datapath.

## Interface
Parameters:
- `ALU_LAT`, default 1: ALU settle cycles between driving operands and capturing results; legal range 1..15.

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  synchronous reset, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at the rising edge
- `req_a`, `req_b`  in  32 (word_t)  operands
- `req_op`  in  5 (regbits_t)  ALU opcode
- `PortA`, `PortB`  out  32  registered operands to the ALU
- `ALUOP`  out  5  registered opcode to the ALU
- `OutputPort`  in  32  ALU result
- `NegFlag`, `Overflow`, `ZeroFlag`  in  1 each  ALU flags
- `rsp_valid`  out  1  response held valid
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready` at the rising edge
- `rsp_result`  out  32  captured result
- `rsp_neg`, `rsp_ovf`, `rsp_zero`  out  1 each  captured flags
- `clr_sticky`  in  1  clears sticky overflow state
- `ovf_sticky`  out  1  overflow seen since last clear
- `ovf_count`  out  8  saturating count of overflowing results

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On handshake: load `req_a`/`req_b`/`req_op` into `PortA`/`PortB`/`ALUOP`, load `cnt`=`ALU_LAT`, go to WAIT.
- WAIT: `req_ready`=0 and `cnt` decrements each cycle. When `cnt`==1:
  - capture `OutputPort`, `NegFlag`, `Overflow` and `ZeroFlag` into the `rsp_*` registers;
  - set `rsp_valid`=1 and go to RESP.
- RESP: `rsp_valid`=1 and `req_ready`=`rsp_ready`, which is combinational pass-through.
  - `rsp_ready & req_valid`: consume the response, load the new request, and go to WAIT. `rsp_valid` drops for that WAIT period.
  - `rsp_ready` only: go to IDLE with `rsp_valid`=0.
  - Neither: hold. `rsp_*` stay stable.
- `PortA`, `PortB` and `ALUOP` hold their last values in IDLE and RESP; they change only on request acceptance.
- `rsp_result` and the flags hold their last captured values after consumption. Only `rsp_valid` qualifies them.
- The block performs no arithmetic. All values pass through bit-exact.

## Timing
- Reset: state=IDLE, `cnt`=0, `PortA`=`PortB`=0, `ALUOP`=0, `rsp_valid`=0, `rsp_result`=0, all `rsp_*` flags=0, `ovf_sticky`=0, `ovf_count`=0. `req_ready`=1 in the cycle after reset releases.
- Request accepted at edge E0; ALU ports update after E0; capture at edge E(`ALU_LAT`); `rsp_valid` high after that edge.
- Latency from request acceptance to `rsp_valid` is `ALU_LAT` cycles.
- Back-to-back throughput is one op per `ALU_LAT`+1 cycles, because the RESP cycle overlaps with the next acceptance.
- `RST` asserted mid-WAIT or mid-RESP discards the in-flight op with no response. Sticky state and count also reset.
- `req_valid` outside a ready cycle is ignored; the requester must hold its data until the handshake.

## Configuration
- `ALU_DRV_STICKY_EN` defined:
  - At each capture with `Overflow`=1: `ovf_sticky` is set and `ovf_count` increments, saturating at 255.
  - `clr_sticky`=1 clears both at the edge.
  - If `clr_sticky` and an overflow capture fall in the same cycle, clear wins.
- Not defined:
  - `ovf_sticky` and `ovf_count` are tied to 0 and `clr_sticky` is ignored.
  - The port list is unchanged.

## Test plan
- Reset, then ADD `req_a`=3, `req_b`=4, `ALU_LAT`=1, bench ALU model -> `PortA`=3, `PortB`=4 one cycle after accept; next cycle `rsp_valid`=1, `rsp_result`=7, all flags 0.
- ADD 0x7FFFFFFF + 1 -> `rsp_result`=0x80000000, `rsp_neg`=1, `rsp_ovf`=1, `rsp_zero`=0. With the macro: `ovf_sticky`=1, `ovf_count`=1.
- SUB 5 - 5 with `rsp_ready` held 0 for 4 cycles -> `rsp_valid` and `rsp_zero`=1 held stable; `req_ready`=0 throughout; release -> IDLE.
- Four back-to-back requests, `rsp_ready`=1, `ALU_LAT`=3 -> responses in order, 4 cycles apart.
- Assert `RST` during WAIT -> no `rsp_valid` appears and all outputs return to their reset values.
- With the macro: 300 overflowing ops -> `ovf_count`=255. Then `clr_sticky` asserted in the same cycle as an overflow capture -> `ovf_count`=0, `ovf_sticky`=0.
